ps2_event_rx: RTL

- Parametrised PS/2 keyboard receiver, successor to the fixed release-only scancode receiver.
- Deserialises PS/2 frames, checks start, parity and stop bits, and enforces an inter-bit timeout.
- Decodes E0 (extended) and F0 (break) prefixes into make/break events and buffers them in a first-word-fall-through FIFO with a valid/ready pop interface.
- Sits between the PS/2 pins and the display/control logic on the pixel clock domain.

---
 rtl/ps2_event_rx.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_event_rx.sv
// PS/2 keyboard receiver: frame checking, E0/F0 prefix decoding
// and a first-word-fall-through event FIFO with valid/ready pop.
module ps2_event_rx #(
    parameter int SYNC_LEN       = 8,
    parameter int FIFO_DEPTH     = 8,
    parameter int ADDR_W         = 3,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ps2clk,
    input  logic              ps2data,
    output logic [7:0]        ev_code,
    output logic              ev_brk,
    output logic              ev_ext,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [ADDR_W:0]   fifo_count,
    output logic              parity_err,
    output logic              frame_err,
    output logic              ovf_err
);
    localparam int HALF = SYNC_LEN / 2;
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                state_q, state_d;
    logic [SYNC_LEN-1:0]   samp_q;
    logic [1:0]            dsync_q;
    logic                  fall_edge, edge_ok, bit_in;
    logic [7:0]            shift_q, shift_d;
    logic [2:0]            bitcnt_q, bitcnt_d;
    logic                  par_q, par_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  tmo_hit;
    logic                  byte_ok, perr, ferr;
    logic                  ext_q, ext_d, brk_q, brk_d;
    logic                  push, push_ok, pop;
    logic [9:0]            mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ADDR_W:0]       cnt_q, cnt_d;
    logic [9:0]            head;
    logic                  perr_q, ferr_q, ovf_q;

    assign fall_edge = (&samp_q[SYNC_LEN-1:HALF]) & ~(|samp_q[HALF-1:0]);
    assign bit_in    = dsync_q[1];
    // A frame stalls once TIMEOUT_CYCLES have elapsed since its last edge.
    assign tmo_hit   = (state_q != S_IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign edge_ok   = fall_edge & ~tmo_hit;
    assign tmo_d     = (state_q == S_IDLE || fall_edge) ? '0 : tmo_q + TW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            samp_q  <= '0;
            dsync_q <= '0;
        end else begin
            samp_q  <= {samp_q[SYNC_LEN-2:0], ps2clk};
            dsync_q <= {dsync_q[0], ps2data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (tmo_hit) begin
            state_d = S_IDLE;
        end else if (fall_edge) begin
            unique case (state_q)
                S_IDLE:   if (!bit_in) state_d = S_DATA;
                S_DATA:   if (bitcnt_q == 3'd7) state_d = S_PARITY;
                S_PARITY: state_d = S_STOP;
                S_STOP:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        par_d    = par_q;
        byte_ok  = 1'b0;
        perr     = 1'b0;
        ferr     = tmo_hit;
        if (edge_ok) begin
            unique case (state_q)
                S_IDLE: bitcnt_d = '0;
                S_DATA: begin
                    shift_d  = {bit_in, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                end
                S_PARITY: par_d = bit_in;
                S_STOP: begin
                    if (!(^shift_q ^ par_q)) perr = 1'b1;
                    else if (!bit_in)        ferr = 1'b1;
                    else                     byte_ok = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q  <= '0;
            bitcnt_q <= '0;
            par_q    <= 1'b0;
            tmo_q    <= '0;
        end else begin
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            par_q    <= par_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        ext_d = ext_q;
        brk_d = brk_q;
        push  = 1'b0;
        if (perr || ferr) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_ok) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    assign ev_valid = (cnt_q != '0);
    assign pop      = ev_valid & ev_ready;
    assign push_ok  = push & ((cnt_q != (ADDR_W+1)'(FIFO_DEPTH)) | pop);
    assign wptr_d   = push_ok ? wptr_q + ADDR_W'(1) : wptr_q;
    assign rptr_d   = pop ? rptr_q + ADDR_W'(1) : rptr_q;

    always_comb begin
        cnt_d = cnt_q;
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + (ADDR_W+1)'(1);
            2'b01:   cnt_d = cnt_q - (ADDR_W+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            ext_q  <= ext_d;
            brk_q  <= brk_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            perr_q <= perr;
            ferr_q <= ferr;
            ovf_q  <= push & ~push_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= {brk_q, ext_q, shift_q};
    end

    // Storage is not reset, so the head is masked while empty.
    assign head       = ev_valid ? mem_q[rptr_q] : '0;
    assign ev_brk     = head[9];
    assign ev_ext     = head[8];
    assign ev_code    = head[7:0];
    assign fifo_count = cnt_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign ovf_err    = ovf_q;
endmodule
